// File: rtl/ahblite_default_slave_err.sv
// AHB-Lite default slave: answers unmapped accesses with ERROR or fixed-data OKAY after optional
// wait states, and logs the first fault plus a saturating fault count. Optional IRQ: AHB_DEFSLV_IRQ_EN.
module ahblite_default_slave_err #(
  parameter int unsigned WAIT_STATES = 0,
  parameter bit          ERR_RESP    = 1'b1,
  parameter logic [31:0] RDATA_VALUE = 32'h0000_0000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [3:0]       HPROT,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic [1:0]       HRESP,
  input  logic             ERR_CLR,
  output logic             ERR_VALID,
  output logic [31:0]      ERR_ADDR,
  output logic             ERR_WRITE,
  output logic [2:0]       ERR_SIZE,
`ifdef AHB_DEFSLV_IRQ_EN
  output logic             ERR_IRQ,
`endif
  output logic [CNT_W-1:0] ERR_COUNT
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ERR1 = 3'd2,
    ST_ERR2 = 3'd3,
    ST_OKAY = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       wr_q;
  logic       resp_err;
  logic       addr_phase_ok;
  logic       accept;
  logic       unused_inputs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only the states that present HREADYOUT=1 can take a new address phase.
  assign addr_phase_ok = (state == ST_IDLE) || (state == ST_ERR2) || (state == ST_OKAY);
  assign accept        = HSEL & HREADY & HTRANS[1] & addr_phase_ok;
  assign HRESP         = {1'b0, resp_err};
  assign unused_inputs = ^{HPROT, HWDATA, HTRANS[0]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      wr_q      <= 1'b0;
      HREADYOUT <= 1'b1;
      resp_err  <= 1'b0;
      HRDATA    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2, ST_OKAY: begin
          if (accept) begin
            wr_q <= HWRITE;
            if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              wait_cnt  <= WAIT_LOAD;
              HREADYOUT <= 1'b0;
              resp_err  <= 1'b0;
              HRDATA    <= 32'h0;
            end else if (ERR_RESP) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              resp_err  <= 1'b1;
              HRDATA    <= 32'h0;
            end else begin
              state     <= ST_OKAY;
              HREADYOUT <= 1'b1;
              resp_err  <= 1'b0;
              HRDATA    <= HWRITE ? 32'h0 : RDATA_VALUE;
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            resp_err  <= 1'b0;
            HRDATA    <= 32'h0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (ERR_RESP) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              resp_err  <= 1'b1;
              HRDATA    <= 32'h0;
            end else begin
              state     <= ST_OKAY;
              HREADYOUT <= 1'b1;
              resp_err  <= 1'b0;
              HRDATA    <= wr_q ? 32'h0 : RDATA_VALUE;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          resp_err  <= 1'b1;
          HRDATA    <= 32'h0;
        end
        default: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          resp_err  <= 1'b0;
          HRDATA    <= 32'h0;
        end
      endcase
    end
  end

  // A clear coinciding with an accept restarts the log with this access already captured.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= 32'h0;
      ERR_WRITE <= 1'b0;
      ERR_SIZE  <= 3'd0;
      ERR_COUNT <= '0;
    end else if (accept) begin
      ERR_COUNT <= ERR_CLR ? CNT_W'(1) : sat_inc(ERR_COUNT);
      if (!ERR_VALID || ERR_CLR) begin
        ERR_VALID <= 1'b1;
        ERR_ADDR  <= HADDR;
        ERR_WRITE <= HWRITE;
        ERR_SIZE  <= HSIZE;
      end
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
      ERR_COUNT <= '0;
    end
  end

`ifdef AHB_DEFSLV_IRQ_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     ERR_IRQ <= 1'b0;
    else if (accept)  ERR_IRQ <= 1'b1;
    else if (ERR_CLR) ERR_IRQ <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ahblite_default_slave_err.sv
// Directed bench for ahblite_default_slave_err: three instances cover ERROR/zero-wait,
// OKAY with wait states, and a narrow saturating counter.
module tb_ahblite_default_slave_err;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic [3:0]  hprot = 4'h0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = 32'h0;
  logic        hready = 1'b1;
  logic        clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

  logic        a_rdy, b_rdy, c_rdy;
  logic [31:0] a_rdata, b_rdata, c_rdata;
  logic [1:0]  a_resp, b_resp, c_resp;
  logic        a_vld, b_vld, c_vld;
  logic [31:0] a_eaddr, b_eaddr, c_eaddr;
  logic        a_ewr, b_ewr, c_ewr;
  logic [2:0]  a_esz, b_esz, c_esz;
  logic [7:0]  a_cnt, b_cnt;
  logic [1:0]  c_cnt;
`ifdef AHB_DEFSLV_IRQ_EN
  logic        a_irq, b_irq, c_irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ahblite_default_slave_err #(.WAIT_STATES(0), .ERR_RESP(1'b1), .RDATA_VALUE(32'h0), .CNT_W(8)) u_a (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_a), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(a_rdy),
    .HRDATA(a_rdata), .HRESP(a_resp), .ERR_CLR(clr_a), .ERR_VALID(a_vld), .ERR_ADDR(a_eaddr),
    .ERR_WRITE(a_ewr), .ERR_SIZE(a_esz),
`ifdef AHB_DEFSLV_IRQ_EN
    .ERR_IRQ(a_irq),
`endif
    .ERR_COUNT(a_cnt));

  ahblite_default_slave_err #(.WAIT_STATES(3), .ERR_RESP(1'b0), .RDATA_VALUE(32'hDEAD_BEEF), .CNT_W(8)) u_b (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_b), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(b_rdy),
    .HRDATA(b_rdata), .HRESP(b_resp), .ERR_CLR(clr_b), .ERR_VALID(b_vld), .ERR_ADDR(b_eaddr),
    .ERR_WRITE(b_ewr), .ERR_SIZE(b_esz),
`ifdef AHB_DEFSLV_IRQ_EN
    .ERR_IRQ(b_irq),
`endif
    .ERR_COUNT(b_cnt));

  ahblite_default_slave_err #(.WAIT_STATES(0), .ERR_RESP(1'b1), .RDATA_VALUE(32'h0), .CNT_W(2)) u_c (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_c), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HPROT(hprot), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(c_rdy),
    .HRDATA(c_rdata), .HRESP(c_resp), .ERR_CLR(clr_c), .ERR_VALID(c_vld), .ERR_ADDR(c_eaddr),
    .ERR_WRITE(c_ewr), .ERR_SIZE(c_esz),
`ifdef AHB_DEFSLV_IRQ_EN
    .ERR_IRQ(c_irq),
`endif
    .ERR_COUNT(c_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_rdy", 32'(a_rdy), 32'd1);
    check("rst_resp", 32'(a_resp), 32'd0);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_cnt", 32'(a_cnt), 32'd0);
    check("rst_vld", 32'(a_vld), 32'd0);
`ifdef AHB_DEFSLV_IRQ_EN
    check("rst_irq", 32'(a_irq), 32'd0);
`endif

    // Zero-wait ERROR read
    sel_a = 1'b1; htrans = 2'b10; haddr = 32'h4000_1000; hwrite = 1'b0; hsize = 3'd2;
    step();
    check("err1_rdy", 32'(a_rdy), 32'd0);
    check("err1_resp", 32'(a_resp), 32'd1);
    sel_a = 1'b0; htrans = 2'b00;
    step();
    check("err2_rdy", 32'(a_rdy), 32'd1);
    check("err2_resp", 32'(a_resp), 32'd1);
    check("log_addr", a_eaddr, 32'h4000_1000);
    check("log_write", 32'(a_ewr), 32'd0);
    check("log_size", 32'(a_esz), 32'd2);
    check("log_cnt", 32'(a_cnt), 32'd1);
    check("log_vld", 32'(a_vld), 32'd1);
    step();
    check("post_err_rdy", 32'(a_rdy), 32'd1);
    check("post_err_resp", 32'(a_resp), 32'd0);

    // Three wait states then OKAY read data
    sel_b = 1'b1; htrans = 2'b10; haddr = 32'h0000_0100; hwrite = 1'b0;
    step();
    check("b_wait1_rdy", 32'(b_rdy), 32'd0);
    sel_b = 1'b0; htrans = 2'b00;
    step();
    check("b_wait2_rdy", 32'(b_rdy), 32'd0);
    step();
    check("b_wait3_rdy", 32'(b_rdy), 32'd0);
    check("b_wait3_resp", 32'(b_resp), 32'd0);
    step();
    check("b_rd_rdy", 32'(b_rdy), 32'd1);
    check("b_rd_resp", 32'(b_resp), 32'd0);
    check("b_rd_data", b_rdata, 32'hDEAD_BEEF);
    step();
    check("b_idle_data", b_rdata, 32'h0);
    sel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0200;
    step();
    sel_b = 1'b0; htrans = 2'b00;
    repeat (2) step();
    check("b_wr_wait_rdy", 32'(b_rdy), 32'd0);
    step();
    check("b_wr_rdy", 32'(b_rdy), 32'd1);
    check("b_wr_data", b_rdata, 32'h0);
    check("b_cnt", 32'(b_cnt), 32'd2);
    check("b_log_addr", b_eaddr, 32'h0000_0100);

    // Clear alone: count and valid drop, capture holds
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    check("clr_vld", 32'(a_vld), 32'd0);
    check("clr_cnt", 32'(a_cnt), 32'd0);
    check("clr_addr_hold", a_eaddr, 32'h4000_1000);
`ifdef AHB_DEFSLV_IRQ_EN
    check("clr_irq", 32'(a_irq), 32'd0);
`endif

    // Back-to-back writes; the second address is held through ERR1 and taken in ERR2
    sel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10;
    step();
    check("b2b_e1a_rdy", 32'(a_rdy), 32'd0);
    check("b2b_e1a_resp", 32'(a_resp), 32'd1);
    haddr = 32'h20;
    step();
    check("b2b_e2a_rdy", 32'(a_rdy), 32'd1);
    check("b2b_e2a_resp", 32'(a_resp), 32'd1);
    check("b2b_cnt_mid", 32'(a_cnt), 32'd1);
    step();
    htrans = 2'b00;
    check("b2b_e1b_rdy", 32'(a_rdy), 32'd0);
    check("b2b_e1b_resp", 32'(a_resp), 32'd1);
    step();
    check("b2b_e2b_rdy", 32'(a_rdy), 32'd1);
    check("b2b_e2b_resp", 32'(a_resp), 32'd1);
    check("b2b_addr", a_eaddr, 32'h10);
    check("b2b_write", 32'(a_ewr), 32'd1);
    check("b2b_cnt", 32'(a_cnt), 32'd2);

    // IDLE and BUSY with HSEL=1
    htrans = 2'b00;
    step();
    check("idle_rdy", 32'(a_rdy), 32'd1);
    check("idle_resp", 32'(a_resp), 32'd0);
    htrans = 2'b01;
    step();
    check("busy_rdy", 32'(a_rdy), 32'd1);
    check("busy_resp", 32'(a_resp), 32'd0);
    check("busy_cnt", 32'(a_cnt), 32'd2);
    sel_a = 1'b0; htrans = 2'b00;

    // Five faults into a 2-bit counter
    sel_c = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h300;
    repeat (10) step();
    htrans = 2'b00; sel_c = 1'b0;
    step();
    check("sat_cnt", 32'(c_cnt), 32'd3);
    check("sat_addr", c_eaddr, 32'h300);
    step();

    // Clear coinciding with an accept
    sel_a = 1'b1; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b0; clr_a = 1'b1;
    step();
    clr_a = 1'b0; sel_a = 1'b0; htrans = 2'b00;
    check("clracc_vld", 32'(a_vld), 32'd1);
    check("clracc_addr", a_eaddr, 32'h80);
    check("clracc_cnt", 32'(a_cnt), 32'd1);
`ifdef AHB_DEFSLV_IRQ_EN
    check("clracc_irq", 32'(a_irq), 32'd1);
`endif
    repeat (2) step();

    // Reset during WAIT
    sel_b = 1'b1; htrans = 2'b10; haddr = 32'h400; hwrite = 1'b0;
    step();
    sel_b = 1'b0; htrans = 2'b00;
    check("rstw_pre_rdy", 32'(b_rdy), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_rdy", 32'(b_rdy), 32'd1);
    check("rstw_resp", 32'(b_resp), 32'd0);
    check("rstw_cnt", 32'(b_cnt), 32'd0);
    check("rstw_vld", 32'(b_vld), 32'd0);
    check("rstw_a_addr", a_eaddr, 32'h0);
    rst_n = 1'b1;
    repeat (4) step();
    check("rstw_after_rdy", 32'(b_rdy), 32'd1);
    check("rstw_after_data", b_rdata, 32'h0);
    check("rstw_after_cnt", 32'(b_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
